// File: rtl/scope_video_pkg.sv
// Shared 1080p60 timing, default waveform-window bounds and background colours
// for the HDMI scope path (raster source and overlay stage).
package scope_video_pkg;

  localparam int H_ACTIVE = 1920;
  localparam int H_FP     = 88;
  localparam int H_SYNC   = 44;
  localparam int H_BP     = 148;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 1080;
  localparam int V_FP     = 4;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 36;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b1;

  localparam int WIN_X0  = 442;
  localparam int WIN_X1  = 1522;
  localparam int WIN_Y0  = 9;
  localparam int WIN_Y1  = 1075;
  localparam int GRID_DX = 108;
  localparam int GRID_DY = 133;

  localparam logic [23:0] OUT_COLOR    = 24'h000000;
  localparam logic [23:0] BG_COLOR     = 24'h101010;
  localparam logic [23:0] GRID_COLOR   = 24'h404040;
  localparam logic [23:0] BORDER_COLOR = 24'hC0C0C0;

  function automatic logic in_span(input logic [11:0] v, input logic [11:0] lo,
                                   input logic [11:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Horizontal/vertical raster counters with registered hs/vs/de.
// Counter values are exposed unregistered so the top can build aligned outputs.
module video_sync_counter
  import scope_video_pkg::*;
#(
  parameter int H_ACTIVE = scope_video_pkg::H_ACTIVE,
  parameter int H_FP     = scope_video_pkg::H_FP,
  parameter int H_SYNC   = scope_video_pkg::H_SYNC,
  parameter int H_BP     = scope_video_pkg::H_BP,
  parameter int V_ACTIVE = scope_video_pkg::V_ACTIVE,
  parameter int V_FP     = scope_video_pkg::V_FP,
  parameter int V_SYNC   = scope_video_pkg::V_SYNC,
  parameter int V_BP     = scope_video_pkg::V_BP,
  parameter bit HS_POL   = scope_video_pkg::HS_POL,
  parameter bit VS_POL   = scope_video_pkg::VS_POL
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  output logic [11:0] h_cnt_o,
  output logic [11:0] v_cnt_o,
  output logic        line_end_o,
  output logic        active_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o
);

  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] HA     = 12'(H_ACTIVE);
  localparam logic [11:0] VA     = 12'(V_ACTIVE);
  localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic        line_end, active;

  assign line_end = (h_cnt_q == H_LAST);
  assign active   = (h_cnt_q < HA) && (v_cnt_q < VA);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    de_d    = 1'b0;
    if (en) begin
      h_cnt_d = line_end ? 12'd0 : h_cnt_q + 12'd1;
      if (line_end) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
      end
      // v_cnt only moves at line end, so vs edges land on h_cnt==0
      hs_d = (h_cnt_q >= HS_ON && h_cnt_q < HS_OFF) ? HS_POL : ~HS_POL;
      vs_d = (v_cnt_q >= VS_ON && v_cnt_q < VS_OFF) ? VS_POL : ~VS_POL;
      de_d = active;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
    end
  end

  assign h_cnt_o    = h_cnt_q;
  assign v_cnt_o    = v_cnt_q;
  assign line_end_o = line_end;
  assign active_o   = active;
  assign hs_o       = hs_q;
  assign vs_o       = vs_q;
  assign de_o       = de_q;

endmodule

// File: rtl/scope_grid_timing_gen.sv
// 1080p60 raster source that paints the scope background: outside colour,
// window border and graticule lines, with registered x/y and frame-start.
module scope_grid_timing_gen
  import scope_video_pkg::*;
#(
  parameter int          H_ACTIVE     = scope_video_pkg::H_ACTIVE,
  parameter int          H_FP         = scope_video_pkg::H_FP,
  parameter int          H_SYNC       = scope_video_pkg::H_SYNC,
  parameter int          H_BP         = scope_video_pkg::H_BP,
  parameter int          V_ACTIVE     = scope_video_pkg::V_ACTIVE,
  parameter int          V_FP         = scope_video_pkg::V_FP,
  parameter int          V_SYNC       = scope_video_pkg::V_SYNC,
  parameter int          V_BP         = scope_video_pkg::V_BP,
  parameter bit          HS_POL       = scope_video_pkg::HS_POL,
  parameter bit          VS_POL       = scope_video_pkg::VS_POL,
  parameter int          WIN_X0       = scope_video_pkg::WIN_X0,
  parameter int          WIN_X1       = scope_video_pkg::WIN_X1,
  parameter int          WIN_Y0       = scope_video_pkg::WIN_Y0,
  parameter int          WIN_Y1       = scope_video_pkg::WIN_Y1,
  parameter int          GRID_DX      = scope_video_pkg::GRID_DX,
  parameter int          GRID_DY      = scope_video_pkg::GRID_DY,
  parameter logic [23:0] OUT_COLOR    = scope_video_pkg::OUT_COLOR,
  parameter logic [23:0] BG_COLOR     = scope_video_pkg::BG_COLOR,
  parameter logic [23:0] GRID_COLOR   = scope_video_pkg::GRID_COLOR,
  parameter logic [23:0] BORDER_COLOR = scope_video_pkg::BORDER_COLOR
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [23:0] o_data,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start
);

  generate
    if (WIN_X1 >= H_ACTIVE || WIN_Y1 >= V_ACTIVE || GRID_DX < 2 || GRID_DY < 2) begin : g_cfg_err
      $error("scope_grid_timing_gen: window exceeds active area or grid pitch below 2");
    end
  endgenerate

  localparam logic [11:0] X0      = 12'(WIN_X0);
  localparam logic [11:0] X1      = 12'(WIN_X1);
  localparam logic [11:0] Y0      = 12'(WIN_Y0);
  localparam logic [11:0] Y1      = 12'(WIN_Y1);
  localparam logic [11:0] DX_LAST = 12'(GRID_DX - 1);
  localparam logic [11:0] DY_LAST = 12'(GRID_DY - 1);

  logic [11:0] h_cnt, v_cnt;
  logic        line_end, active;

  video_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_sync (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .en        (en),
    .h_cnt_o   (h_cnt),
    .v_cnt_o   (v_cnt),
    .line_end_o(line_end),
    .active_o  (active),
    .hs_o      (o_hs),
    .vs_o      (o_vs),
    .de_o      (o_de)
  );

  logic [11:0] gx_q, gx_d, gy_q, gy_d, gx_cur, gy_cur;
  logic [23:0] data_q, data_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        fs_q, fs_d;
  logic        in_win, border;

  // Phase counters are forced to 0 on the first window column/row, so the
  // current pixel's phase is valid in the same cycle the counter is aligned.
  assign gx_cur = (h_cnt == X0) ? 12'd0 : gx_q;
  assign gy_cur = (v_cnt == Y0) ? 12'd0 : gy_q;
  assign in_win = in_span(h_cnt, X0, X1) && in_span(v_cnt, Y0, Y1);
  assign border = (h_cnt == X0) || (h_cnt == X1) || (v_cnt == Y0) || (v_cnt == Y1);

  always_comb begin
    gx_d   = gx_q;
    gy_d   = gy_q;
    data_d = 24'h0;
    x_d    = '0;
    y_d    = '0;
    fs_d   = 1'b0;
    if (en) begin
      gx_d = (gx_cur == DX_LAST) ? 12'd0 : gx_cur + 12'd1;
      if (line_end && in_span(v_cnt, Y0, Y1)) begin
        gy_d = (gy_cur == DY_LAST) ? 12'd0 : gy_cur + 12'd1;
      end
      if (active) begin
        x_d  = h_cnt;
        y_d  = v_cnt;
        fs_d = (h_cnt == 12'd0) && (v_cnt == 12'd0);
        if (!in_win)                             data_d = OUT_COLOR;
        else if (border)                         data_d = BORDER_COLOR;
        else if (gx_cur == 12'd0 || gy_cur == 12'd0) data_d = GRID_COLOR;
        else                                     data_d = BG_COLOR;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      gx_q   <= '0;
      gy_q   <= '0;
      data_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
    end else begin
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      data_q <= data_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
    end
  end

  assign o_data        = data_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame_start = fs_q;

endmodule
